// File: rtl/avmm_pkg.sv
// Shared types and constants for the Avalon-MM read responder.
package avmm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_FULL
  } resp_state_e;

  localparam logic [15:0] AVMM_BAD_DATA = 16'hDEAD;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1: taps on bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/resp_pipe.sv
// LATENCY-deep valid/data shift register; data in a stage only moves when valid,
// so the output word holds its last returned value between responses.
module resp_pipe #(
  parameter int LATENCY = 3,
  parameter int WIDTH   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [LATENCY-1:0] valid_q, valid_d;
  logic [WIDTH-1:0]   data_q [LATENCY];
  logic [WIDTH-1:0]   data_d [LATENCY];

  always_comb begin
    valid_d    = '0;
    data_d     = data_q;
    valid_d[0] = in_valid;
    data_d[0]  = in_valid ? in_data : data_q[0];
    for (int i = 1; i < LATENCY; i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = valid_q[i-1] ? data_q[i-1] : data_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      data_q  <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/avmm_read_responder.sv
// Avalon-MM read-only responder over a preloadable 16-bit word buffer.
// Optional random waitrequest injection: define AVMM_RESPONDER_STALL_EN.
module avmm_read_responder
  import avmm_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          LATENCY     = 3,
  parameter int          MAX_PENDING = 2,
  localparam int         AW          = $clog2(DEPTH),
  localparam int         PW          = $clog2(MAX_PENDING + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   address,
  input  logic          read,
  output logic          waitrequest,
  output logic [15:0]   readdata,
  output logic          readdatavalid,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [15:0]   load_data,
  output logic          err
);

  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

  logic [15:0]   mem [DEPTH];
  logic [30:0]   offs_word;
  logic          offs_lsb_unused;
  logic [AW-1:0] word_idx;
  logic          in_range;
  logic          accept;
  logic          stall;
  logic [15:0]   rd_word;

  logic          ready_q;
  logic [PW-1:0] pend_q, pend_d;
  logic          err_q, err_d;
  resp_state_e   state_q, state_d;

  assign {offs_word, offs_lsb_unused} = address - BASE_ADDR;
  assign word_idx = offs_word[AW-1:0];
  assign in_range = (offs_word[30:AW] == '0);

  // ready_q keeps waitrequest high until the first edge after reset release
  assign waitrequest = ~ready_q | (pend_q == PEND_MAX) | stall;
  assign accept      = read & ~waitrequest;
  assign rd_word     = in_range ? mem[word_idx] : AVMM_BAD_DATA;

  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  resp_pipe #(
    .LATENCY (LATENCY),
    .WIDTH   (16)
  ) u_resp_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (accept),
    .in_data   (rd_word),
    .out_valid (readdatavalid),
    .out_data  (readdata)
  );

`ifdef AVMM_RESPONDER_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    pend_d = pend_q + PW'(accept) - PW'(readdatavalid);
    err_d  = err_q | (accept & (address[0] | ~in_range));
  end

  // State only mirrors pend; kept for debug visibility
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = (pend_d == PEND_MAX) ? ST_FULL : ST_BUSY;
      ST_BUSY: begin
        if (pend_d == PEND_MAX) state_d = ST_FULL;
        else if (pend_d == '0)  state_d = ST_IDLE;
      end
      ST_FULL: if (pend_d != PEND_MAX) state_d = (pend_d == '0) ? ST_IDLE : ST_BUSY;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q <= 1'b0;
      pend_q  <= '0;
      err_q   <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      ready_q <= 1'b1;
      pend_q  <= pend_d;
      err_q   <= err_d;
      state_q <= state_d;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_avmm_read_responder.sv
// Directed + randomized bench for avmm_read_responder against a queue-based response model.
module tb_avmm_read_responder;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0;
  localparam int          LAT   = 3;
  localparam int          MAXP  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic        read;
  logic        waitrequest;
  logic [15:0] readdata;
  logic        readdatavalid;
  logic        load_en;
  logic [9:0]  load_addr;
  logic [15:0] load_data;
  logic        err;

  avmm_read_responder #(
    .DEPTH       (DEPTH),
    .BASE_ADDR   (BASE),
    .LATENCY     (LAT),
    .MAX_PENDING (MAXP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .address       (address),
    .read          (read),
    .waitrequest   (waitrequest),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .load_en       (load_en),
    .load_addr     (load_addr),
    .load_data     (load_data),
    .err           (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int          due;
  } rsp_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [15:0] model_mem [DEPTH];
  rsp_t        q[$];
  logic [15:0] last_data = 16'h0;
  logic        model_err = 1'b0;
  logic        model_ready = 1'b0;
  logic        last_acc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs against the model, account for this cycle's
  // request/load, then advance to the next falling edge.
  task automatic cycle();
    logic        exp_wr;
    logic [31:0] offs;
    logic [31:0] word;
    logic        inr;
    rsp_t        r;
    exp_wr = !model_ready || (q.size() == MAXP);
`ifdef AVMM_RESPONDER_STALL_EN
    chk("waitrequest_full", {31'b0, waitrequest | !exp_wr}, 32'd1);
`else
    chk("waitrequest", {31'b0, waitrequest}, {31'b0, exp_wr});
`endif
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("readdatavalid", {31'b0, readdatavalid}, 32'd1);
      chk("readdata", {16'b0, readdata}, {16'b0, q[0].data});
      last_data = q[0].data;
      void'(q.pop_front());
    end else begin
      chk("readdatavalid_idle", {31'b0, readdatavalid}, 32'd0);
      chk("readdata_hold", {16'b0, readdata}, {16'b0, last_data});
    end
    chk("err", {31'b0, err}, {31'b0, model_err});
    last_acc = reset && read && !waitrequest;
    if (last_acc) begin
      offs = address - BASE;
      word = offs >> 1;
      inr  = (word < DEPTH);
      r.data = inr ? model_mem[word] : 16'hDEAD;
      r.due  = cyc + LAT;
      q.push_back(r);
      if (address[0] || !inr) model_err = 1'b1;
    end
    if (load_en) model_mem[load_addr] = load_data;
    @(posedge clk);
    cyc++;
    if (reset) model_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    read  = 1'b0;
    q.delete();
    last_data   = 16'h0;
    model_err   = 1'b0;
    model_ready = 1'b0;
    #1;
    for (int i = 0; i < n; i++) cycle();
    reset = 1'b1;
    #1;
    cycle();
`ifndef AVMM_RESPONDER_STALL_EN
    chk("wr_after_release", {31'b0, waitrequest}, 32'd0);
`endif
  endtask

  task automatic issue_read(input logic [31:0] addr);
    read    = 1'b1;
    address = addr;
    for (int k = 0; k < 64 && waitrequest; k++) cycle();
    if (waitrequest) chk("accept_timeout", {31'b0, waitrequest}, 32'd0);
    cycle();
    read = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < LAT + 2; i++) cycle();
    chk("drained", q.size(), 32'd0);
  endtask

  task automatic read_and_expect(input string tag, input logic [31:0] addr, input logic [15:0] exp);
    issue_read(addr);
    for (int i = 0; i < LAT - 1; i++) cycle();
    chk({tag, "_valid"}, {31'b0, readdatavalid}, 32'd1);
    chk({tag, "_data"}, {16'b0, readdata}, {16'b0, exp});
    drain();
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    logic [31:0] a;
    r = $urandom_range(0, 99);
    if (r < 5) return BASE + 2 * DEPTH + 2 * $urandom_range(0, 4095);
    if (r < 8) return BASE - 2;
    a = BASE + 2 * $urandom_range(0, DEPTH - 1);
    if (r < 15) a[0] = 1'b1;
    return a;
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int stall_cnt;
    reset     = 1'b0;
    read      = 1'b0;
    address   = 32'h0;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    @(negedge clk);
    do_reset(3);

    // Preload the whole buffer; word 7 starts at zero for the same-edge test
    for (int i = 0; i < DEPTH; i++) begin
      load_en   = 1'b1;
      load_addr = 10'(i);
      load_data = (i == 7) ? 16'h0000 : 16'($urandom);
      cycle();
    end
    load_en = 1'b0;

    // Single read
    load_en = 1'b1; load_addr = 10'd5; load_data = 16'h3F80;
    cycle();
    load_en = 1'b0;
    read_and_expect("single", 32'h0A, 16'h3F80);
    chk("single_err", {31'b0, err}, 32'd0);

    // Back-pressure: four back-to-back reads with MAX_PENDING=2
    issue_read(BASE + 2);
    read = 1'b1; address = BASE + 4;
    for (int k = 0; k < 64 && waitrequest; k++) cycle();
    cycle();
`ifndef AVMM_RESPONDER_STALL_EN
    address = BASE + 6;
    chk("bp_third_wr", {31'b0, waitrequest}, 32'd1);
`endif
    issue_read(BASE + 6);
    issue_read(BASE + 8);
    drain();

    // Bad accesses
    read_and_expect("out_of_range", BASE + 2 * DEPTH, 16'hDEAD);
    chk("oor_err", {31'b0, err}, 32'd1);
    read_and_expect("misaligned", 32'h0B, 16'h3F80);
    chk("misaligned_err", {31'b0, err}, 32'd1);

    // Same-edge load and read of word 7
    load_en = 1'b1; load_addr = 10'd7; load_data = 16'h1234;
    read = 1'b1; address = 32'h0E;
    for (int k = 0; k < 64 && waitrequest; k++) cycle();
    cycle();
    load_en = 1'b0; read = 1'b0;
    for (int i = 0; i < LAT - 1; i++) cycle();
`ifndef AVMM_RESPONDER_STALL_EN
    chk("same_edge_old", {16'b0, readdata}, 32'h0000);
`endif
    drain();
    read_and_expect("reread", 32'h0E, 16'h1234);

    // Reset with two reads in flight
    issue_read(32'h0A);
    issue_read(32'h0C);
    do_reset(2);
    drain();
    read_and_expect("post_reset", 32'h0A, 16'h3F80);

    // Randomized traffic; an unaccepted request is held until accepted
    for (int i = 0; i < 500; i++) begin
      if (!(read && !last_acc)) begin
        read    = ($urandom_range(0, 99) < 60);
        address = rand_addr();
      end
      load_en   = ($urandom_range(0, 99) < 20);
      load_addr = 10'($urandom_range(0, DEPTH - 1));
      load_data = 16'($urandom);
      cycle();
    end
    read = 1'b0; load_en = 1'b0;
    drain();

`ifdef AVMM_RESPONDER_STALL_EN
    stall_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      if (waitrequest) stall_cnt++;
      cycle();
    end
    chk("stall_duty", {31'b0, (stall_cnt >= 200 && stall_cnt <= 300)}, 32'd1);
`else
    stall_cnt = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
